// File: rtl/wave_gen_pkg.sv
// Shared state codes, mode codes and direction flags for the waveform generator FSM.
package wave_gen_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_N1_SEL   = 3'd1;
   localparam logic [2:0] ST_N2_SEL   = 3'd2;
   localparam logic [2:0] ST_S_SEL    = 3'd3;
   localparam logic [2:0] ST_RUN_WAIT = 3'd4;
   localparam logic [2:0] ST_RUN      = 3'd5;

   localparam logic [1:0] MODE_TRI    = 2'd0;
   localparam logic [1:0] MODE_SAW_UP = 2'd1;
   localparam logic [1:0] MODE_SAW_DN = 2'd2;
   localparam logic [1:0] MODE_HOLD   = 2'd3;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/wave_gen_fsm_if.sv
// Operator front-end / display-side signal bundle for wave_gen_fsm.
interface wave_gen_fsm_if #(
   parameter int unsigned W = 8
);
   logic         v_i;
   logic         ST_i;
   logic [1:0]   mode_i;
   logic [W-1:0] din_i;
   logic [W-1:0] dind_o;
   logic [W-1:0] n1_o;
   logic [W-1:0] n2_o;
   logic [W-1:0] step_o;
   logic [W-1:0] wave_o;
   logic         err_o;
   logic [2:0]   state_o;

   modport master (
      output v_i, ST_i, mode_i, din_i,
      input  dind_o, n1_o, n2_o, step_o, wave_o, err_o, state_o
   );

   modport slave (
      input  v_i, ST_i, mode_i, din_i,
      output dind_o, n1_o, n2_o, step_o, wave_o, err_o, state_o
   );
endinterface

// File: rtl/wave_step_unit.sv
// Combinational next-offset/direction calculator; sums carried in W+1 bits so nothing wraps.
module wave_step_unit
   import wave_gen_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] offset_i,
   input  logic [W-1:0] span_i,
   input  logic [W-1:0] step_i,
   input  logic         dir_i,
   input  logic [1:0]   mode_i,
   output logic [W-1:0] offset_next_o,
   output logic         dir_next_o
);

   logic [W:0] off_w;
   logic [W:0] span_w;
   logic [W:0] step_w;
   logic [W:0] sum_w;

   assign off_w  = {1'b0, offset_i};
   assign span_w = {1'b0, span_i};
   assign step_w = {1'b0, step_i};
   assign sum_w  = off_w + step_w;

   always_comb begin
      offset_next_o = offset_i;
      dir_next_o    = dir_i;
      case (mode_i)
         MODE_TRI: begin
            if (dir_i == DIR_UP) begin
               if (sum_w >= span_w) begin
                  offset_next_o = span_i;
                  dir_next_o    = DIR_DN;
               end else begin
                  offset_next_o = sum_w[W-1:0];
               end
            end else begin
               if (off_w <= step_w) begin
                  offset_next_o = '0;
                  dir_next_o    = DIR_UP;
               end else begin
                  offset_next_o = offset_i - step_i;
               end
            end
         end
         MODE_SAW_UP: begin
            if (sum_w > span_w) offset_next_o = '0;
            else                offset_next_o = sum_w[W-1:0];
         end
         MODE_SAW_DN: begin
            if (off_w < step_w) offset_next_o = span_i;
            else                offset_next_o = offset_i - step_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/wave_gen_fsm.sv
// Bound/step entry FSM driving a triangle/sawtooth sweep between N1 and N2.
// Optional macro WGEN_BTN_EDGE_EN: rising-edge detect on v_i and ST_i.
module wave_gen_fsm
   import wave_gen_pkg::*;
#(
   parameter int unsigned W      = 8,
   parameter int unsigned RST_N2 = 1
) (
   input  logic           clc_i,
   input  logic           rst_i,
   wave_gen_fsm_if.slave  bus
);

   logic [2:0]   state_q,  state_d;
   logic [W-1:0] n1_q,     n1_d;
   logic [W-1:0] n2_q,     n2_d;
   logic [W-1:0] step_q,   step_d;
   logic [W-1:0] offset_q, offset_d;
   logic         dir_q,    dir_d;
   logic [W-1:0] dind_q,   dind_d;
   logic         err_q,    err_d;

   logic         v_evt;
   logic         st_evt;
   logic [W-1:0] span;
   logic [W-1:0] off_nx;
   logic         dir_nx;

`ifdef WGEN_BTN_EDGE_EN
   logic v_prev_q;
   logic st_prev_q;

   always_ff @(posedge clc_i or negedge rst_i) begin
      if (!rst_i) begin
         v_prev_q  <= 1'b0;
         st_prev_q <= 1'b0;
      end else begin
         v_prev_q  <= bus.v_i;
         st_prev_q <= bus.ST_i;
      end
   end

   assign v_evt  = bus.v_i  & ~v_prev_q;
   assign st_evt = bus.ST_i & ~st_prev_q;
`else
   assign v_evt  = bus.v_i;
   assign st_evt = bus.ST_i;
`endif

   assign span = n2_q - n1_q;

   wave_step_unit #(.W(W)) u_step (
      .offset_i      (offset_q),
      .span_i        (span),
      .step_i        (step_q),
      .dir_i         (dir_q),
      .mode_i        (bus.mode_i),
      .offset_next_o (off_nx),
      .dir_next_o    (dir_nx)
   );

   always_comb begin
      state_d  = state_q;
      n1_d     = n1_q;
      n2_d     = n2_q;
      step_d   = step_q;
      offset_d = offset_q;
      dir_d    = dir_q;
      dind_d   = dind_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (v_evt) state_d = ST_N1_SEL;
         end
         ST_N1_SEL: begin
            dind_d = bus.din_i;
            if (v_evt) begin
               n1_d    = bus.din_i;
               state_d = ST_N2_SEL;
            end
         end
         ST_N2_SEL: begin
            dind_d = bus.din_i;
            if (v_evt) begin
               if (bus.din_i > n1_q) begin
                  n2_d    = bus.din_i;
                  err_d   = 1'b0;
                  state_d = ST_S_SEL;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         ST_S_SEL: begin
            dind_d = bus.din_i;
            if (v_evt) begin
               step_d   = (bus.din_i == '0) ? W'(1) : bus.din_i;
               offset_d = '0;
               dir_d    = DIR_UP;
               state_d  = ST_RUN_WAIT;
            end
         end
         ST_RUN_WAIT: begin
            dind_d = n1_q + offset_q;
            if (v_evt)       state_d = ST_N1_SEL;
            else if (st_evt) state_d = ST_RUN;
         end
         ST_RUN: begin
            // dind tracks the offset this edge commits, so it matches wave_o afterwards
            if (v_evt) begin
               offset_d = '0;
               dir_d    = DIR_UP;
               dind_d   = n1_q;
               state_d  = ST_N1_SEL;
            end else if (st_evt) begin
               dind_d   = n1_q + offset_q;
               state_d  = ST_RUN_WAIT;
            end else begin
               offset_d = off_nx;
               dir_d    = dir_nx;
               dind_d   = n1_q + off_nx;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clc_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         n1_q     <= '0;
         n2_q     <= W'(RST_N2);
         step_q   <= W'(1);
         offset_q <= '0;
         dir_q    <= DIR_UP;
         dind_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n1_q     <= n1_d;
         n2_q     <= n2_d;
         step_q   <= step_d;
         offset_q <= offset_d;
         dir_q    <= dir_d;
         dind_q   <= dind_d;
         err_q    <= err_d;
      end
   end

   assign bus.dind_o  = dind_q;
   assign bus.n1_o    = n1_q;
   assign bus.n2_o    = n2_q;
   assign bus.step_o  = step_q;
   assign bus.wave_o  = n1_q + offset_q;
   assign bus.err_o   = err_q;
   assign bus.state_o = state_q;

endmodule
